// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, NOP encoding, queue entry layout.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus: valid/ready request channel plus an in-order response channel.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush; head word readable combinationally, no write-through bypass.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests, queues returned
// words with their PC, and discards responses that were in flight across a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  instr_fetch_unit_if.master  imem,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  input  logic                instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW:0]     outstanding;
  logic            fifo_empty;
  logic            fifo_full;
  logic            req_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Every request must have a guaranteed queue slot, so in-flight words count against capacity.
  assign outstanding    = {1'b0, inflight} + {1'b0, count};
  assign imem.req_valid = reset_n && !redirect && (outstanding < CREDIT_MAX);
  assign imem.req_addr  = fetch_pc;
  assign req_fire       = imem.req_valid && imem.req_ready;

  assign push       = imem.rsp_valid && (discard == '0) && !redirect;
  assign pop        = instr_valid && instr_ready && !redirect;
  assign push_entry = '{pc: rsp_pc, instr: imem.rsp_data};

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : head.instr;
  assign instr_pc    = fifo_empty ? '0 : head.pc;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .din     (push_entry),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  // On redirect, everything still in flight (minus a word landing now) becomes stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect) begin
      fetch_pc <= word_align(redirect_pc);
      rsp_pc   <= word_align(redirect_pc);
      inflight <= inflight - CW'(imem.rsp_valid);
      discard  <= inflight - CW'(imem.rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(imem.rsp_valid);
      if (imem.rsp_valid) begin
        if (discard != '0) discard <= discard - CW'(1);
        else               rsp_pc  <= rsp_pc + 32'd4;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) (push && !pop) |-> !fifo_full);

endmodule
